// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory writer.
package imem_pkg;

    localparam int unsigned IMEM_DATA_W = 8;
    localparam int unsigned IMEM_ADDR_W = 7;
    localparam int unsigned IMEM_DEPTH  = 128;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } imem_wr_state_t;

endpackage

// File: rtl/imem_ram_1r1w.sv
// One-write / one-registered-read RAM; a same-address read returns the old word.
module imem_ram_1r1w
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Array is left unreset so it maps onto block RAM; only the output register clears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_writer.sv
// Streams a byte load into the instruction RAM while holding the CPU at address 0.
module imem_writer
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    imem_wr_state_t    state_q, state_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic              done_d, err_d;
    logic              we;
    logic              len_ok;
    logic [ADDR_W-1:0] ea;

    assign len_ok = (len != '0) && (len <= DEPTH_L);

    always_comb begin
        state_d  = state_q;
        wptr_d   = wptr_q;
        rem_d    = rem_q;
        wr_ready = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        state_d = LOAD;
                        wptr_d  = '0;
                        rem_d   = len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    we    = 1'b1;
                    rem_d = rem_q - (ADDR_W + 1)'(1);
                    // Pointer holds on the final write so it never rolls past DEPTH-1.
                    if (rem_q == (ADDR_W + 1)'(1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        wptr_d = wptr_q + ADDR_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rem_q   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rem_q   <= rem_d;
            done    <= done_d;
            err     <= err_d;
            busy    <= (state_d != IDLE);
        end
    end

    assign cpu_hold = busy;
    assign ea       = cpu_hold ? '0 : rd_addr;

    imem_ram_1r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (ea),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_imem_writer.sv
// Directed self-checking bench for imem_writer.
`timescale 1ns/1ps
module tb_imem_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       busy;
    logic       done;
    logic       err;
    logic       cpu_hold;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    int unsigned busy_cyc;
    int unsigned done_cnt;
    int unsigned rdy_cnt;

    always #5 clk = ~clk;

    imem_writer #(
        .DATA_W (8),
        .ADDR_W (7),
        .DEPTH  (128)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        step();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; len = 8'd0;
        wr_data = 8'd0; wr_valid = 1'b0; rd_addr = 7'd0;
        step(); step();
        reset = 1'b0;

        // Give the array its identity image mem[i]=i before the directed checks.
        start = 1'b1; len = 8'd128;
        step();
        start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_valid = 1'b0;
        chk("pre_done", 32'(done), 32'd1);
        step();

        // Reset state
        reset = 1'b1;
        step();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b0;

        // Idle reads
        rd_chk("idle_rd5", 7'd5, 8'd5);
        rd_chk("idle_rd10", 7'd10, 8'd10);
        chk("idle_hold", 32'(cpu_hold), 32'd0);
        chk("idle_wr_ready", 32'(wr_ready), 32'd0);

        // Reset mid-load, with read/write collision at address 0
        rd_addr = 7'd7; start = 1'b1; len = 8'd8;
        step();
        start = 1'b0;
        chk("rml_busy", 32'(busy), 32'd1);
        chk("rml_rd_pre", 32'(rd_data), 32'd7);
        wr_valid = 1'b1; wr_data = 8'h55;
        step();
        chk("coll_old", 32'(rd_data), 32'd0);
        wr_data = 8'h56;
        step();
        chk("coll_new", 32'(rd_data), 32'h55);
        wr_data = 8'h57;
        step();
        #1 reset = 1'b1;
        #1;
        chk("rml_busy_drop", 32'(busy), 32'd0);
        chk("rml_hold_drop", 32'(cpu_hold), 32'd0);
        chk("rml_rdy_drop", 32'(wr_ready), 32'd0);
        chk("rml_no_done", 32'(done), 32'd0);
        wr_valid = 1'b0;
        step();
        reset = 1'b0;
        rd_chk("rml_m0", 7'd0, 8'h55);
        rd_chk("rml_m1", 7'd1, 8'h56);
        rd_chk("rml_m2", 7'd2, 8'h57);
        rd_chk("rml_m3", 7'd3, 8'h03);

        // Load 4 bytes, valid continuously high
        rd_addr = 7'd10; start = 1'b1; len = 8'd4;
        busy_cyc = 0; done_cnt = 0; rdy_cnt = 0;
        step();
        start = 1'b0;
        if (busy) busy_cyc++;
        chk("ld4_rd_pre", 32'(rd_data), 32'd10);
        for (int i = 0; i < 4; i++) begin
            if (wr_ready) rdy_cnt++;
            wr_valid = 1'b1; wr_data = 8'(8'hA0 + i);
            step();
            if (busy) busy_cyc++;
            if (done) done_cnt++;
        end
        wr_valid = 1'b0;
        chk("ld4_done", 32'(done), 32'd1);
        chk("ld4_rdy_in_done", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (wr_ready) rdy_cnt++;
            step();
            if (busy) busy_cyc++;
            if (done) done_cnt++;
        end
        chk("ld4_rdy_cycles", 32'(rdy_cnt), 32'd4);
        chk("ld4_busy_cycles", 32'(busy_cyc), 32'd5);
        chk("ld4_done_pulses", 32'(done_cnt), 32'd1);
        rd_chk("ld4_m0", 7'd0, 8'hA0);
        rd_chk("ld4_m1", 7'd1, 8'hA1);
        rd_chk("ld4_m2", 7'd2, 8'hA2);
        rd_chk("ld4_m3", 7'd3, 8'hA3);
        rd_chk("ld4_m4", 7'd4, 8'h04);

        // Stalled stream, len=3, two-cycle gaps
        rd_addr = 7'd7; start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        wr_valid = 1'b1; wr_data = 8'hC0;
        step();
        chk("stl_rd_old", 32'(rd_data), 32'hA0);
        wr_valid = 1'b0; wr_data = 8'hEE;
        step();
        chk("stl_rd_forced", 32'(rd_data), 32'hC0);
        chk("stl_rdy_gap", 32'(wr_ready), 32'd1);
        step();
        chk("stl_busy_gap", 32'(busy), 32'd1);
        wr_valid = 1'b1; wr_data = 8'hC1;
        step();
        wr_valid = 1'b0; wr_data = 8'hEF;
        step();
        step();
        chk("stl_no_early_done", 32'(done), 32'd0);
        wr_valid = 1'b1; wr_data = 8'hC2;
        step();
        wr_valid = 1'b0;
        chk("stl_done", 32'(done), 32'd1);
        step();
        chk("stl_done_clr", 32'(done), 32'd0);
        chk("stl_idle", 32'(busy), 32'd0);
        rd_chk("stl_m0", 7'd0, 8'hC0);
        rd_chk("stl_m1", 7'd1, 8'hC1);
        rd_chk("stl_m2", 7'd2, 8'hC2);
        rd_chk("stl_m3", 7'd3, 8'hA3);

        // Illegal lengths
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_rdy", 32'(wr_ready), 32'd0);
        step();
        chk("len0_err_clr", 32'(err), 32'd0);
        start = 1'b1; len = 8'd129;
        step();
        start = 1'b0;
        chk("len129_err", 32'(err), 32'd1);
        chk("len129_busy", 32'(busy), 32'd0);
        step();
        chk("len129_err_clr", 32'(err), 32'd0);

        // Full 128-byte load with a start pulse mid-load
        start = 1'b1; len = 8'd128;
        step();
        start = 1'b0;
        for (int i = 0; i < 128; i++) begin
            wr_valid = 1'b1; wr_data = 8'(i) ^ 8'h5A;
            start = (i == 50);
            len = 8'd4;
            step();
            if (i == 50) chk("mid_start_no_err", 32'(err), 32'd0);
            if (i == 126) chk("full_no_early_done", 32'(done), 32'd0);
        end
        start = 1'b0; wr_valid = 1'b0;
        chk("full_done", 32'(done), 32'd1);
        step();
        chk("full_idle", 32'(busy), 32'd0);
        chk("full_err", 32'(err), 32'd0);
        rd_chk("full_m127", 7'd127, 8'h25);
        rd_chk("full_m126", 7'd126, 8'h24);
        rd_chk("full_m0", 7'd0, 8'h5A);
        rd_chk("full_m54", 7'd54, 8'h6C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_writer.md
Name: imem_writer

Overview:
- Write-side counterpart of the 128x8 instruction ROM: a 128x8 synchronous RAM that is filled from a byte stream using a valid/ready handshake.
- The CPU reads it through a registered read port with 1-cycle latency.
- While a load runs, the block holds the CPU (cpu_hold) and forces the read address to 0. The CPU therefore restarts from address 0 once the load completes.

Parameters:
- DATA_W, 8, width of a memory word.
- ADDR_W, 7, address width.
- DEPTH, 128, number of words (2**ADDR_W).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- len  in  ADDR_W+1  number of bytes to load; legal range 1..DEPTH.
- wr_data  in  DATA_W  stream byte.
- wr_valid  in  1  wr_data is valid.
- wr_ready  out  1  block accepts a byte this cycle.
- busy  out  1  high in LOAD and DONE.
- done  out  1  one-cycle pulse after the last byte is written.
- err  out  1  one-cycle pulse when start arrives with an illegal len.
- cpu_hold  out  1  holds the CPU while loading; equal to busy.
- rd_addr  in  ADDR_W  CPU read address.
- rd_data  out  DATA_W  registered read data.

Behaviour:
- FSM states: IDLE, LOAD, DONE. Reset returns the FSM to IDLE.
- Reset values:
  - wr_ready=0, busy=0, done=0, err=0, cpu_hold=0, rd_data=0.
  - Write pointer wptr=0, remaining count rem=0.
  - Memory contents are not reset; simulation initial contents are mem[i]=i.
- IDLE:
  - wr_ready=0.
  - start=1 with 1<=len<=DEPTH: next cycle goes to LOAD, wptr=0, rem=len.
  - start=1 with len=0 or len>DEPTH: err=1 for the next cycle; stay in IDLE.
- LOAD:
  - wr_ready=1 combinationally.
  - A transfer occurs when wr_valid && wr_ready. On it: mem[wptr] <= wr_data, wptr increments, rem decrements.
  - wr_valid low stalls the load with no timeout.
  - The transfer with rem==1 moves the FSM to DONE.
- DONE: done=1, wr_ready=0, then IDLE on the next cycle. Total hold time is therefore the accepted transfers plus one cycle.
- wptr never wraps: len<=DEPTH ensures the last write lands at DEPTH-1.
- start asserted outside IDLE is ignored, with no err.
- Read port:
  - Effective address ea = cpu_hold ? 0 : rd_addr.
  - rd_data <= mem[ea] on every rising clk edge.
  - When a read and a write hit the same address in the same cycle, rd_data returns the old data (read-before-write).
- Reset during LOAD:
  - Aborts immediately and returns to IDLE; cpu_hold drops asynchronously.
  - Bytes already written remain; no done pulse.
- done and err are registered, so they are glitch-free.

Decomposition:
- Shared package imem_pkg:
  - constants IMEM_DATA_W=8, IMEM_ADDR_W=7, IMEM_DEPTH=128.
  - typedef enum logic [1:0] {IDLE, LOAD, DONE} imem_wr_state_t.
- Sub-module imem_ram_1r1w:
  - one write port (we, waddr, wdata) and one registered read port (raddr, rdata).
  - read-before-write behaviour.
  - no reset on the array; reset only on rdata.
  - imem_writer contains the FSM, counters and address mux.

Test Plan:
- Reset then idle reads: rd_addr=5, 10 -> rd_data=5 one cycle later, then 10; cpu_hold=0; wr_ready=0.
- Load 4 bytes with wr_valid continuously high: start with len=4, stream A0,A1,A2,A3 -> wr_ready high for 4 cycles; done pulses once; busy high for 5 cycles. Afterwards reading addresses 0..3 returns A0..A3 and address 4 returns 4.
- Stalled stream: len=3 with wr_valid gaps of 2 cycles -> only valid cycles write; done appears one cycle after the 3rd transfer. During the load, rd_addr=7 gives rd_data=mem[0]=C0, the first byte already written, because the address is forced to 0.
- Illegal len:
  - len=0 -> err pulse, no state change.
  - len=129 -> err pulse.
  - len=128 full load -> last byte is written at address 127 with no wrap.
- Reset mid-load: len=8, assert reset after 3 bytes -> busy, cpu_hold and wr_ready all drop immediately; no done; addresses 0..2 hold the new bytes and address 3 still reads 3.
- Read/write collision and ignored start:
  - while cpu_hold=1, byte 55 is written to address 0 -> rd_data returns the old mem[0] that cycle and 55 the following cycle.
  - start pulsed mid-load -> ignored, no err.
